instr_decode_queue: RTL and testbench

Decode-stage front end for the MIPS pipeline: buffers fetched instructions in a DEPTH-entry FIFO, predecodes the head entry and presents a registered decode bundle to the issue/execute side under valid/ready handshakes. Adds behaviour the combinational decoder lacks: buffering with backpressure, flush, branch-delay-slot tracking across cycles, reserved-instruction detection, and a mode parameter for the CACHE instruction. Sits between the fetch unit and the main decode/issue logic.

---
 rtl/cpu_def.sv | 86 ++++++++
 rtl/instr_predecode.sv | 121 ++++++++++++
 rtl/instr_decode_queue.sv | 156 +++++++++++++++
 tb/tb_instr_decode_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_def.sv
// Shared MIPS decode definitions: opcode/funct encodings, instruction-class
// indices and predecode bundle field widths.
package cpu_def;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 5;
  localparam int OP_W    = 6;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_COP0   = 6'b010000;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_CACHE  = 6'b101111;

  localparam logic [5:0] F_SLL     = 6'b000000;
  localparam logic [5:0] F_SRL     = 6'b000010;
  localparam logic [5:0] F_SRA     = 6'b000011;
  localparam logic [5:0] F_SLLV    = 6'b000100;
  localparam logic [5:0] F_SRLV    = 6'b000110;
  localparam logic [5:0] F_SRAV    = 6'b000111;
  localparam logic [5:0] F_JR      = 6'b001000;
  localparam logic [5:0] F_JALR    = 6'b001001;
  localparam logic [5:0] F_SYSCALL = 6'b001100;
  localparam logic [5:0] F_BREAK   = 6'b001101;
  localparam logic [5:0] F_MFHI    = 6'b010000;
  localparam logic [5:0] F_MTHI    = 6'b010001;
  localparam logic [5:0] F_MFLO    = 6'b010010;
  localparam logic [5:0] F_MTLO    = 6'b010011;
  localparam logic [5:0] F_MULT    = 6'b011000;
  localparam logic [5:0] F_MULTU   = 6'b011001;
  localparam logic [5:0] F_DIV     = 6'b011010;
  localparam logic [5:0] F_DIVU    = 6'b011011;
  localparam logic [5:0] F_ADD     = 6'b100000;
  localparam logic [5:0] F_ADDU    = 6'b100001;
  localparam logic [5:0] F_SUB     = 6'b100010;
  localparam logic [5:0] F_SUBU    = 6'b100011;
  localparam logic [5:0] F_AND     = 6'b100100;
  localparam logic [5:0] F_OR      = 6'b100101;
  localparam logic [5:0] F_XOR     = 6'b100110;
  localparam logic [5:0] F_NOR     = 6'b100111;
  localparam logic [5:0] F_SLT     = 6'b101010;
  localparam logic [5:0] F_SLTU    = 6'b101011;
  localparam logic [5:0] F_ERET    = 6'b011000;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [4:0] RS_MFC0   = 5'b00000;
  localparam logic [4:0] RS_MTC0   = 5'b00100;
  // bits [25:6] of ERET: CO bit set, everything else zero
  localparam logic [19:0] ERET_BODY = 20'h80000;

  localparam logic [4:0] REG_RA    = 5'd31;

  localparam int CLS_BRANCH = 0;
  localparam int CLS_ERET   = 1;
  localparam int CLS_MTC0   = 2;
  localparam int CLS_CACHE  = 3;
  localparam int CLS_N      = 4;

  typedef logic [CLS_N-1:0] cls_vec_t;

endpackage

// File: rtl/instr_predecode.sv
// Combinational predecode of one MIPS instruction word into register
// addresses, write enable, class flags and a reserved-instruction flag.
module instr_predecode
  import cpu_def::*;
#(
  parameter int SUPPORT_CACHE = 1
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               fexc,
  output logic [REG_W-1:0]   a1,
  output logic [REG_W-1:0]   a2,
  output logic [REG_W-1:0]   a3,
  output logic               regwrite,
  output logic               is_branch,
  output logic               eret,
  output logic               mtc0,
  output logic               cache_req,
  output logic               ri
);

  logic [INSTR_W-1:0] word_s;
  logic [OP_W-1:0]    op_s;
  logic [5:0]         funct_s;
  logic [REG_W-1:0]   rs_s;
  logic [REG_W-1:0]   rt_s;
  logic [REG_W-1:0]   rd_s;
  logic [REG_W-1:0]   dst_s;
  logic               legal_s;
  logic               wr_s;
  cls_vec_t           cls_s;

  // Decode the (fexc-masked) word; anything not matched is reserved.
  always_comb begin
    word_s   = fexc ? 32'h0000_0000 : instr;
    op_s     = word_s[31:26];
    rs_s     = word_s[25:21];
    rt_s     = word_s[20:16];
    rd_s     = word_s[15:11];
    funct_s  = word_s[5:0];
    legal_s  = 1'b1;
    wr_s     = 1'b0;
    dst_s    = 5'd0;
    cls_s    = '0;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          F_JR: cls_s[CLS_BRANCH] = 1'b1;
          F_JALR: begin
            cls_s[CLS_BRANCH] = 1'b1;
            wr_s  = 1'b1;
            dst_s = rd_s;
          end
          F_SYSCALL, F_BREAK, F_MTHI, F_MTLO,
          F_MULT, F_MULTU, F_DIV, F_DIVU: wr_s = 1'b0;
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MFLO,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: begin
            wr_s  = 1'b1;
            dst_s = rd_s;
          end
          default: legal_s = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        case (rt_s)
          RT_BLTZ, RT_BGEZ: cls_s[CLS_BRANCH] = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            cls_s[CLS_BRANCH] = 1'b1;
            wr_s  = 1'b1;
            dst_s = REG_RA;
          end
          default: legal_s = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls_s[CLS_BRANCH] = 1'b1;
      OP_JAL: begin
        cls_s[CLS_BRANCH] = 1'b1;
        wr_s  = 1'b1;
        dst_s = REG_RA;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        wr_s  = 1'b1;
        dst_s = rt_s;
      end
      OP_SB, OP_SH, OP_SW: wr_s = 1'b0;
      OP_COP0: begin
        if (rs_s == RS_MFC0) begin
          wr_s  = 1'b1;
          dst_s = rt_s;
        end else if (rs_s == RS_MTC0) begin
          cls_s[CLS_MTC0] = 1'b1;
        end else if ((word_s[25:6] == ERET_BODY) && (funct_s == F_ERET)) begin
          cls_s[CLS_ERET] = 1'b1;
        end else begin
          legal_s = 1'b0;
        end
      end
      OP_CACHE: begin
        if (SUPPORT_CACHE != 0) begin
          cls_s[CLS_CACHE] = 1'b1;
        end else begin
          legal_s = 1'b0;
        end
      end
      default: legal_s = 1'b0;
    endcase
  end

  // A write to $0 is no write, so the NOP that a fetch exception becomes has regwrite = 0.
  assign a1        = rs_s;
  assign a2        = rt_s;
  assign regwrite  = legal_s && wr_s && (dst_s != 5'd0);
  assign a3        = regwrite ? dst_s : 5'd0;
  assign is_branch = legal_s && cls_s[CLS_BRANCH];
  assign eret      = legal_s && cls_s[CLS_ERET];
  assign mtc0      = legal_s && cls_s[CLS_MTC0];
  assign cache_req = legal_s && cls_s[CLS_CACHE];
  assign ri        = !legal_s;

endmodule

// File: rtl/instr_decode_queue.sv
// Decode-stage front end: DEPTH-entry instruction FIFO feeding a registered
// predecode bundle, with flush and branch-delay-slot tracking.
module instr_decode_queue
  import cpu_def::*;
#(
  parameter int DEPTH         = 4,
  parameter int PC_WIDTH      = 32,
  parameter int SUPPORT_CACHE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       in_fexc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [31:0]                out_instr,
  output logic [4:0]                 out_a1,
  output logic [4:0]                 out_a2,
  output logic [4:0]                 out_a3,
  output logic                       out_regwrite,
  output logic                       out_is_branch,
  output logic                       out_bd,
  output logic                       out_eret,
  output logic                       out_mtc0,
  output logic                       out_cache_req,
  output logic                       out_ri,
  output logic                       out_fexc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_WIDTH-1:0] pc_mem_r    [DEPTH];
  logic [31:0]         instr_mem_r [DEPTH];
  logic                fexc_mem_r  [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                last_branch_r;
  logic                push_s;
  logic                load_s;
  logic                head_fexc_s;
  logic [31:0]         head_instr_s;

  logic [4:0] pd_a1_s;
  logic [4:0] pd_a2_s;
  logic [4:0] pd_a3_s;
  logic       pd_regwrite_s;
  logic       pd_is_branch_s;
  logic       pd_eret_s;
  logic       pd_mtc0_s;
  logic       pd_cache_req_s;
  logic       pd_ri_s;

  assign count        = count_r;
  assign in_ready     = (count_r < CNT_W'(DEPTH));
  assign push_s       = in_valid && in_ready && !flush;
  assign load_s       = (count_r != '0) && (!out_valid || out_ready) && !flush;
  assign head_fexc_s  = fexc_mem_r[rd_ptr_r];
  assign head_instr_s = head_fexc_s ? 32'h0000_0000 : instr_mem_r[rd_ptr_r];

  instr_predecode #(
    .SUPPORT_CACHE (SUPPORT_CACHE)
  ) u_predecode (
    .instr     (instr_mem_r[rd_ptr_r]),
    .fexc      (head_fexc_s),
    .a1        (pd_a1_s),
    .a2        (pd_a2_s),
    .a3        (pd_a3_s),
    .regwrite  (pd_regwrite_s),
    .is_branch (pd_is_branch_s),
    .eret      (pd_eret_s),
    .mtc0      (pd_mtc0_s),
    .cache_req (pd_cache_req_s),
    .ri        (pd_ri_s)
  );

  // FIFO storage write; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= in_pc;
      instr_mem_r[wr_ptr_r] <= in_instr;
      fexc_mem_r[wr_ptr_r]  <= in_fexc;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(load_s);
    end
  end

  // Output bundle register and delay-slot tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_instr     <= 32'h0000_0000;
      out_a1        <= 5'd0;
      out_a2        <= 5'd0;
      out_a3        <= 5'd0;
      out_regwrite  <= 1'b0;
      out_is_branch <= 1'b0;
      out_bd        <= 1'b0;
      out_eret      <= 1'b0;
      out_mtc0      <= 1'b0;
      out_cache_req <= 1'b0;
      out_ri        <= 1'b0;
      out_fexc      <= 1'b0;
      last_branch_r <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      last_branch_r <= 1'b0;
    end else if (load_s) begin
      out_valid     <= 1'b1;
      out_pc        <= pc_mem_r[rd_ptr_r];
      out_instr     <= head_instr_s;
      out_a1        <= pd_a1_s;
      out_a2        <= pd_a2_s;
      out_a3        <= pd_a3_s;
      out_regwrite  <= pd_regwrite_s;
      out_is_branch <= pd_is_branch_s;
      out_bd        <= last_branch_r;
      out_eret      <= pd_eret_s;
      out_mtc0      <= pd_mtc0_s;
      out_cache_req <= pd_cache_req_s;
      out_ri        <= pd_ri_s;
      out_fexc      <= head_fexc_s;
      last_branch_r <= pd_is_branch_s;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed self-checking bench for instr_decode_queue (DEPTH = 4), with a
// second instance built with SUPPORT_CACHE = 0 sharing the same stimulus.
module tb_instr_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_fexc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_a1, out_a2, out_a3;
  logic        out_regwrite, out_is_branch, out_bd, out_eret, out_mtc0;
  logic        out_cache_req, out_ri, out_fexc;
  logic [2:0]  count;

  logic        nc_in_ready, nc_out_valid;
  logic [31:0] nc_out_pc, nc_out_instr;
  logic [4:0]  nc_out_a1, nc_out_a2, nc_out_a3;
  logic        nc_out_regwrite, nc_out_is_branch, nc_out_bd, nc_out_eret;
  logic        nc_out_mtc0, nc_out_cache_req, nc_out_ri, nc_out_fexc;
  logic [2:0]  nc_count;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I_BEQ  = 32'h1000_0003;
  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_LW   = 32'h8C22_0000;

  always #5 clk = ~clk;

  instr_decode_queue #(.DEPTH(4), .PC_WIDTH(32), .SUPPORT_CACHE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_fexc(in_fexc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3),
    .out_regwrite(out_regwrite), .out_is_branch(out_is_branch), .out_bd(out_bd),
    .out_eret(out_eret), .out_mtc0(out_mtc0), .out_cache_req(out_cache_req),
    .out_ri(out_ri), .out_fexc(out_fexc), .count(count)
  );

  instr_decode_queue #(.DEPTH(4), .PC_WIDTH(32), .SUPPORT_CACHE(0)) dut_nc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nc_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_fexc(in_fexc), .flush(flush),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_pc(nc_out_pc),
    .out_instr(nc_out_instr), .out_a1(nc_out_a1), .out_a2(nc_out_a2),
    .out_a3(nc_out_a3), .out_regwrite(nc_out_regwrite),
    .out_is_branch(nc_out_is_branch), .out_bd(nc_out_bd), .out_eret(nc_out_eret),
    .out_mtc0(nc_out_mtc0), .out_cache_req(nc_out_cache_req), .out_ri(nc_out_ri),
    .out_fexc(nc_out_fexc), .count(nc_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Enqueue one entry and wait (bounded) until its bundle is presented.
  task automatic send_one(input logic [31:0] pc, input logic [31:0] instr, input logic fexc);
    in_valid = 1'b1; in_pc = pc; in_instr = instr; in_fexc = fexc;
    step();
    in_valid = 1'b0; in_fexc = 1'b0;
    for (int t = 0; t < 8 && !out_valid; t++) step();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL send_wait pc=%h out_valid=%b required=1", pc, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_fexc = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d required=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h required=0", out_pc); end
    rst = 1'b0;
  endtask

  task automatic test_ori();
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h3402_0005;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ori_no_bypass got=%b required=0", out_valid); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL ori_count1 got=%0d required=1", count); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ori_valid got=%b required=1", out_valid); end
    checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL ori_pc got=%h required=100", out_pc); end
    checks++; if (out_a1 !== 5'd0) begin failures++; $display("FAIL ori_a1 got=%0d required=0", out_a1); end
    checks++; if (out_a3 !== 5'd2) begin failures++; $display("FAIL ori_a3 got=%0d required=2", out_a3); end
    checks++; if (out_regwrite !== 1'b1) begin failures++; $display("FAIL ori_regwrite got=%b required=1", out_regwrite); end
    checks++; if (out_ri !== 1'b0) begin failures++; $display("FAIL ori_ri got=%b required=0", out_ri); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL ori_count0 got=%0d required=0", count); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ori_drained got=%b required=0", out_valid); end
  endtask

  task automatic test_backpressure();
    int seen;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * i); in_instr = 32'h3400_0000 | 32'(i + 1) << 16;
      step();
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_full_count got=%0d required=4", count); end
    in_pc = 32'h2FC;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b required=0", in_ready); end
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_hold_count got=%0d required=4", count); end
      checks++; if (out_pc !== 32'h200) begin failures++; $display("FAIL bp_hold_pc got=%h required=200", out_pc); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(4 * j)) begin
        failures++; $display("FAIL bp_order idx=%0d got_valid=%b got_pc=%h required_pc=%h", j, out_valid, out_pc, 32'h200 + 32'(4 * j));
      end
      step();
    end
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL bp_empty valid=%b count=%0d required 0/0", out_valid, count); end
    // Twelve back-to-back entries wrap the pointers three times.
    seen = 0;
    for (int t = 0; t < 40 && seen < 12; t++) begin
      if (t < 12) begin
        in_valid = 1'b1; in_pc = 32'h300 + 32'(4 * t); in_instr = 32'h3403_0000;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid) begin
        checks++;
        if (out_pc !== 32'h300 + 32'(4 * seen)) begin
          failures++; $display("FAIL wrap_order idx=%0d got=%h required=%h", seen, out_pc, 32'h300 + 32'(4 * seen));
        end
        seen++;
      end
    end
    in_valid = 1'b0;
    checks++; if (seen !== 12) begin failures++; $display("FAIL wrap_count got=%0d required=12", seen); end
  endtask

  task automatic test_delay_slot();
    do_flush();
    out_ready = 1'b1;
    send_one(32'h400, I_BEQ, 1'b0);
    checks++; if (out_bd !== 1'b0 || out_is_branch !== 1'b1) begin failures++; $display("FAIL ds_beq bd=%b br=%b required 0/1", out_bd, out_is_branch); end
    send_one(32'h404, I_ADDU, 1'b0);
    checks++; if (out_bd !== 1'b1 || out_is_branch !== 1'b0) begin failures++; $display("FAIL ds_addu1 bd=%b br=%b required 1/0", out_bd, out_is_branch); end
    checks++; if (out_a3 !== 5'd3 || out_regwrite !== 1'b1) begin failures++; $display("FAIL ds_addu_dst a3=%0d wr=%b required 3/1", out_a3, out_regwrite); end
    send_one(32'h408, I_ADDU, 1'b0);
    checks++; if (out_bd !== 1'b0 || out_is_branch !== 1'b0) begin failures++; $display("FAIL ds_addu2 bd=%b br=%b required 0/0", out_bd, out_is_branch); end
    send_one(32'h40C, I_JAL, 1'b0);
    checks++; if (out_a3 !== 5'd31 || out_regwrite !== 1'b1 || out_is_branch !== 1'b1) begin
      failures++; $display("FAIL ds_jal a3=%0d wr=%b br=%b required 31/1/1", out_a3, out_regwrite, out_is_branch);
    end
  endtask

  task automatic test_reserved();
    do_flush();
    send_one(32'h600, 32'hFC00_0000, 1'b0);
    checks++; if (out_ri !== 1'b1 || out_regwrite !== 1'b0 || out_a3 !== 5'd0) begin
      failures++; $display("FAIL ri_word ri=%b wr=%b a3=%0d required 1/0/0", out_ri, out_regwrite, out_a3);
    end
    send_one(32'h604, 32'hBC00_0000, 1'b0);
    checks++; if (out_ri !== 1'b0 || out_cache_req !== 1'b1) begin failures++; $display("FAIL cache_on ri=%b cache=%b required 0/1", out_ri, out_cache_req); end
    checks++; if (nc_out_ri !== 1'b1 || nc_out_cache_req !== 1'b0) begin failures++; $display("FAIL cache_off ri=%b cache=%b required 1/0", nc_out_ri, nc_out_cache_req); end
  endtask

  task automatic test_fexc();
    send_one(32'h700, I_LW, 1'b0);
    checks++; if (out_a1 !== 5'd1 || out_a3 !== 5'd2 || out_regwrite !== 1'b1) begin
      failures++; $display("FAIL lw_plain a1=%0d a3=%0d wr=%b required 1/2/1", out_a1, out_a3, out_regwrite);
    end
    send_one(32'h704, I_LW, 1'b1);
    checks++; if (out_fexc !== 1'b1 || out_instr !== 32'h0) begin failures++; $display("FAIL fexc_pass fexc=%b instr=%h required 1/0", out_fexc, out_instr); end
    checks++; if (out_regwrite !== 1'b0 || out_ri !== 1'b0 || out_a3 !== 5'd0) begin
      failures++; $display("FAIL fexc_decode wr=%b ri=%b a3=%0d required 0/0/0", out_regwrite, out_ri, out_a3);
    end
  endtask

  task automatic test_flush();
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h500 + 32'(4 * i); in_instr = (i == 0) ? I_BEQ : I_ADDU;
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3 || out_valid !== 1'b1 || out_is_branch !== 1'b1) begin
      failures++; $display("FAIL flush_setup count=%0d valid=%b br=%b required 3/1/1", count, out_valid, out_is_branch);
    end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h510; in_instr = I_ADDU;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_clear count=%0d valid=%b ready=%b required 0/0/1", count, out_valid, in_ready);
    end
    out_ready = 1'b1;
    send_one(32'h520, I_ADDU, 1'b0);
    checks++; if (out_bd !== 1'b0 || out_pc !== 32'h520) begin failures++; $display("FAIL flush_bd bd=%b pc=%h required 0/520", out_bd, out_pc); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h800 + 32'(4 * i); in_instr = I_ADDU;
      step();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset count=%0d valid=%b required 0/0", count, out_valid);
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ori();
    test_backpressure();
    test_delay_slot();
    test_reserved();
    test_fexc();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
